// File: rtl/popcount_ctrl_pkg.sv
// Shared types and sizing for the popcount stream controller.
// State encoding and result-width derivation live here so checkers can bind to them.
package popcount_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SUM_EXTRA_W = 3;

  // Result width: 8 bits per byte times (2^len_w - 1) bytes fits in len_w+3 bits.
  function automatic int calc_sum_w(input int len_w);
    return len_w + SUM_EXTRA_W;
  endfunction

endpackage

// File: rtl/popcount_byte.sv
// Combinational population count of one byte (result 0..8).
module popcount_byte (
  input  logic [7:0] data,
  output logic [3:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < 8; i++) begin
      count = count + {3'b000, data[i]};
    end
  end

endmodule

// File: rtl/popcount_stream_ctrl.sv
// Counts set bits across a commanded number of streamed bytes and returns the total.
// Per-byte count is registered, then accumulated a cycle later so bytes can stream at 1/cycle.
module popcount_stream_ctrl
  import popcount_ctrl_pkg::*;
#(
  parameter  int LEN_W = 8,
  localparam int SUM_W = calc_sum_w(LEN_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SUM_W-1:0] res_sum,
  output logic [LEN_W-1:0] res_len,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; ready depends only on the state, and abort suppresses every transfer.

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] cnt;
  logic             pend;
  logic [3:0]       pipe;
  logic [SUM_W-1:0] sum;
  logic [LEN_W-1:0] len;
  logic [3:0]       byte_count;
  logic             cmd_fire;
  logic             in_fire;
  logic             res_fire;
  logic             last_byte;

  popcount_byte u_popcount_byte (
    .data  (in_data),
    .count (byte_count)
  );

  assign cmd_ready = (state == IDLE);
  assign in_ready  = (state == ACCUM);
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;
  assign res_sum   = sum;
  assign res_len   = len;

  assign cmd_fire  = cmd_valid && cmd_ready && !abort;
  assign in_fire   = in_valid && in_ready && !abort;
  assign res_fire  = res_valid && res_ready && !abort;
  assign last_byte = (cnt == LEN_W'(1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (cmd_fire) state_nxt = (cmd_len == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        if (in_fire && last_byte) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = DONE;
      DONE: begin
        if (res_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      pend <= 1'b0;
      pipe <= '0;
      sum  <= '0;
      len  <= '0;
    end else if (abort) begin
      cnt  <= '0;
      pend <= 1'b0;
      pipe <= '0;
      sum  <= '0;
    end else if (cmd_fire) begin
      cnt  <= cmd_len;
      len  <= cmd_len;
      sum  <= '0;
      pend <= 1'b0;
    end else begin
      // Drain the previous byte's count while the next byte is captured.
      if (pend) sum <= sum + {{(SUM_W-4){1'b0}}, pipe};
      if (in_fire) begin
        pipe <= byte_count;
        pend <= 1'b1;
        cnt  <= cnt - LEN_W'(1);
      end else begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_popcount_stream_ctrl.sv
// Directed bench for popcount_stream_ctrl: latency, zero length, long job, backpressure,
// abort and asynchronous reset, with hand-computed expected values.
module tb_popcount_stream_ctrl;

  localparam int LEN_W = 8;
  localparam int SUM_W = LEN_W + 3;

  logic             clk;
  logic             rst_n;
  logic             abort;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             res_valid;
  logic             res_ready;
  logic [SUM_W-1:0] res_sum;
  logic [LEN_W-1:0] res_len;
  logic             busy;
  logic [1:0]       state_dbg;

  int checks = 0;
  int errors = 0;
  int xfers;
  int cycles;

  popcount_stream_ctrl #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_len   (res_len),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    check({tag, "_in_ready"},  32'(in_ready), 0);
    check({tag, "_res_valid"}, 32'(res_valid), 0);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_res_sum"},   32'(res_sum), 0);
    check({tag, "_res_len"},   32'(res_len), 0);
    check({tag, "_state"},     32'(state_dbg), 0);
  endtask

  task automatic send_cmd(input logic [LEN_W-1:0] len);
    cmd_valid = 1'b1;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    abort     = 1'b0;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    res_ready = 1'b1;
    #1;
    check_reset_outputs("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Four bytes back-to-back: 8+0+4+2 = 14, result two cycles after last byte.
    send_cmd(8'd4);
    check("t1_in_ready", 32'(in_ready), 1);
    check("t1_cmd_ready", 32'(cmd_ready), 0);
    check("t1_busy", 32'(busy), 1);
    in_valid = 1'b1;
    in_data = 8'hFF; tick();
    in_data = 8'h00; tick();
    in_data = 8'h0F; tick();
    in_data = 8'h81; tick();
    in_valid = 1'b0;
    check("t1_drain_state", 32'(state_dbg), 2);
    check("t1_c1_res_valid", 32'(res_valid), 0);
    tick();
    check("t1_c2_res_valid", 32'(res_valid), 1);
    check("t1_res_sum", 32'(res_sum), 14);
    check("t1_res_len", 32'(res_len), 4);
    tick();
    check("t1_idle_cmd_ready", 32'(cmd_ready), 1);

    // Zero length command completes on the next cycle.
    send_cmd(8'd0);
    check("t2_res_valid", 32'(res_valid), 1);
    check("t2_res_sum", 32'(res_sum), 0);
    check("t2_res_len", 32'(res_len), 0);
    check("t2_in_ready", 32'(in_ready), 0);
    tick();
    check("t2_cmd_ready", 32'(cmd_ready), 1);
    check("t2_in_ready_idle", 32'(in_ready), 0);

    // 255 bytes of 0xFF with random gaps: 255*8 = 2040.
    send_cmd(8'd255);
    xfers = 0;
    cycles = 0;
    in_data = 8'hFF;
    while (!res_valid && cycles < 5000) begin
      in_valid = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) xfers++;
      tick();
      cycles++;
    end
    in_valid = 1'b0;
    check("t3_res_valid_timeout", 32'(res_valid), 1);
    check("t3_res_sum", 32'(res_sum), 2040);
    check("t3_res_len", 32'(res_len), 255);
    check("t3_xfers", 32'(xfers), 255);
    tick();
    check("t3_cmd_ready", 32'(cmd_ready), 1);

    // Backpressure on the result: hold, and refuse a pending second command.
    res_ready = 1'b0;
    send_cmd(8'd1);
    send_byte(8'h3C);
    tick();
    check("t4_res_valid", 32'(res_valid), 1);
    check("t4_res_sum", 32'(res_sum), 4);
    cmd_valid = 1'b1;
    cmd_len   = 8'd5;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_hold_res_valid", 32'(res_valid), 1);
      check("t4_hold_res_sum", 32'(res_sum), 4);
      check("t4_hold_res_len", 32'(res_len), 1);
      check("t4_hold_cmd_ready", 32'(cmd_ready), 0);
    end
    res_ready = 1'b1;
    tick();
    check("t4_after_hs_cmd_ready", 32'(cmd_ready), 1);
    check("t4_after_hs_res_valid", 32'(res_valid), 0);
    tick();
    cmd_valid = 1'b0;
    check("t4_second_in_ready", 32'(in_ready), 1);
    check("t4_second_res_len", 32'(res_len), 5);
    in_valid = 1'b1;
    in_data  = 8'h01;
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0;
    tick();
    check("t4_second_res_valid", 32'(res_valid), 1);
    check("t4_second_res_sum", 32'(res_sum), 5);
    tick();

    // Abort after three bytes, with a byte offered in the abort cycle.
    send_cmd(8'd8);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    check("t5_cmd_ready", 32'(cmd_ready), 1);
    check("t5_busy", 32'(busy), 0);
    check("t5_res_sum", 32'(res_sum), 0);
    check("t5_res_valid", 32'(res_valid), 0);
    check("t5_in_ready", 32'(in_ready), 0);
    send_cmd(8'd1);
    send_byte(8'h07);
    tick();
    check("t5_next_res_valid", 32'(res_valid), 1);
    check("t5_next_res_sum", 32'(res_sum), 3);
    check("t5_next_res_len", 32'(res_len), 1);
    tick();

    // Asynchronous reset mid-job, away from any clock edge.
    send_cmd(8'd4);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    send_cmd(8'd2);
    send_byte(8'hAA);
    send_byte(8'h01);
    tick();
    check("t6_next_res_valid", 32'(res_valid), 1);
    check("t6_next_res_sum", 32'(res_sum), 5);
    check("t6_next_res_len", 32'(res_len), 2);
    tick();
    check("t6_idle", 32'(cmd_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/popcount_stream_ctrl.md
POPCOUNT_STREAM_CTRL -- requirements
Module: popcount_stream_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 8, meaning the width of the byte-count command field (maximum vector length 2^LEN_W-1 bytes).
REQ-002 SHALL define localparam SUM_W = LEN_W+3, meaning the result width, sized so that 8*(2^LEN_W-1) cannot overflow.
REQ-003 SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port abort  input  1  synchronous cancel of the current job.
REQ-006 SHALL have port cmd_valid  input  1  a job command is present.
REQ-007 SHALL have port cmd_ready  output  1  the block can accept a command.
REQ-008 SHALL have port cmd_len  input  LEN_W  number of bytes in the job.
REQ-009 SHALL have port in_valid  input  1  a data byte is present.
REQ-010 SHALL have port in_ready  output  1  the block can accept a data byte.
REQ-011 SHALL have port in_data  input  8  data byte.
REQ-012 SHALL have port res_valid  output  1  the result is available.
REQ-013 SHALL have port res_ready  input  1  the consumer accepts the result.
REQ-014 SHALL have port res_sum  output  SUM_W  total number of set bits in the job.
REQ-015 SHALL have port res_len  output  LEN_W  echo of cmd_len for the job.
REQ-016 SHALL have port busy  output  1  the block is in any state other than IDLE.

Function
REQ-017 SHALL implement an FSM with states IDLE, ACCUM, DRAIN and DONE.
REQ-018 SHALL define the outputs as cmd_ready = (state==IDLE), in_ready = (state==ACCUM), res_valid = (state==DONE), busy = (state!=IDLE).
REQ-019 On cmd_valid&&cmd_ready, SHALL latch cmd_len into res_len and the remaining-byte counter, clear the sum, and go to ACCUM when cmd_len!=0 or to DONE when cmd_len==0.
REQ-020 SHALL treat each in_valid&&in_ready cycle as one byte transfer; it computes popcount(in_data) (0..8) into a 4-bit pipeline register, marks that register pending, and decrements the remaining-byte counter.
REQ-021 SHALL add the pending pipeline value, zero-extended to SUM_W, into the sum on the cycle after its transfer; the add overlaps with the next transfer, so sustained throughput is 1 byte/cycle.
REQ-022 SHALL go from ACCUM to DRAIN on the last byte transfer (counter==1); DRAIN lasts exactly one cycle, adds the final pending value, then goes to DONE.
REQ-023 Latency: for a last byte transferred in cycle c, res_valid SHALL be high in cycle c+2; for a zero-length command accepted in cycle c, res_valid SHALL be high in cycle c+1 with res_sum=0.
REQ-024 SHALL allow in_valid gaps in ACCUM without changing the counter or the sum, apart from draining a pending value.
REQ-025 SHALL hold res_sum and res_len stable while in DONE; on res_valid&&res_ready it goes to IDLE, and cmd_ready is high on the following cycle.
REQ-026 SHALL not accept a new command while the previous result is unconsumed (no command/result overlap).
REQ-027 SHALL give abort priority over all handshakes when high: next state IDLE, the pending flag and counter are cleared, and res_sum is cleared to 0; in the abort cycle no transfer is counted even if in_valid is high.
REQ-028 SHALL keep the sum saturation-free by construction; no overflow logic exists.

Reset
REQ-029 While rst_n=0, SHALL hold state=IDLE, counter=0, pending=0, pipeline register=0, res_sum=0 and res_len=0.
REQ-030 While rst_n=0, SHALL drive cmd_ready=1, in_ready=0, res_valid=0 and busy=0.
REQ-031 SHALL assert reset asynchronously and discard any in-flight job; after release the block waits for a new command.

Structure
REQ-032 SHALL take the state encoding localparams (IDLE=0, ACCUM=1, DRAIN=2, DONE=3) and the SUM_W derivation from the shared package popcount_ctrl_pkg.
REQ-033 SHALL instantiate one combinational sub-module popcount_byte (8-bit in, 4-bit count out) for the per-byte count; all sequencing stays in popcount_stream_ctrl.

Verification
REQ-034 SHALL be verified with: cmd_len=4, bytes 0xFF,0x00,0x0F,0x81 back-to-back, res_ready=1 -> res_valid 2 cycles after the last byte, res_sum=14, res_len=4.
REQ-035 SHALL be verified with: cmd_len=0 -> res_valid the cycle after the command, res_sum=0, in_ready never high.
REQ-036 SHALL be verified with: cmd_len=255, all bytes 0xFF, in_valid toggling randomly -> res_sum=2040 with no overflow, exactly 255 transfers counted.
REQ-037 SHALL be verified with: res_ready held low for 10 cycles in DONE -> res_sum/res_len stable, cmd_ready=0, and a second cmd_valid is not accepted until the result handshake.
REQ-038 SHALL be verified with: cmd_len=8, abort pulsed after 3 bytes with in_valid high -> IDLE next cycle, res_sum=0, the abort-cycle byte is ignored, and a following cmd_len=1 with 0x07 gives res_sum=3.
REQ-039 SHALL be verified with: rst_n dropped mid-ACCUM asynchronously -> outputs reach their reset values immediately, and the next job computes correctly.
